mul_sched: RTL and testbench

- Shares one combinational Booth `multiplier` instance between NREQ requesters.
- Each requester sees a valid/ready request channel; all requesters share one response channel tagged with the requester id.
- The block registers the operands and waits LAT cycles, treating the multiplier as a multicycle path. It then registers the product and holds it until the consumer accepts it.
- Sits between the operand producers (address/filter datapaths) and the shared multiplier, so one multiplier serves several clients.

---
 rtl/mul_sched_pkg.sv | 27 ++
 rtl/mul_sched_rr_arbiter.sv | 57 +++++
 rtl/multiplier.sv | 51 +++++
 rtl/mul_sched.sv | 147 ++++++++++++++
 tb/tb_mul_sched.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mul_sched_pkg.sv
// ---------------------------------------------------------------------------
// mul_sched_pkg
// Shared types and width helpers for the shared-multiplier scheduler.
//   state_t : scheduler FSM states (IDLE, WAIT, RESP)
//   N_DEF   : default operand width
//   RES_W() : product width for an N-bit multiplier (2N+1)
//   ID_W()  : width of a requester index for NREQ requesters (NREQ >= 2)
// ---------------------------------------------------------------------------
package mul_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int N_DEF = 10;

  function automatic int RES_W(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int ID_W(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/mul_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Grants the first asserted request found
// searching upward from i_ptr with wrap-around.
// Ports:
//   i_req   : request vector (NREQ bits)
//   i_ptr   : index of highest-priority requester
//   i_en    : when low, no grant is issued
//   o_grant : one-hot grant (all zero when nothing granted)
//   o_idx   : encoded index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter  int NREQ = 2,
  localparam int IW   = ID_W(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx
);

  // Distance of each requester from the pointer in search order; the
  // requesting entry with the smallest distance wins. Distances are unique,
  // so exactly one winner exists whenever any request is present.
  logic [IW:0] w_dist [NREQ];
  logic        w_found;
  logic [IW:0] w_best;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_dist
      assign w_dist[gi] = ((IW + 1)'(gi) >= {1'b0, i_ptr})
                        ? ((IW + 1)'(gi) - {1'b0, i_ptr})
                        : ((IW + 1)'(gi + NREQ) - {1'b0, i_ptr});
    end
  endgenerate

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_best  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (i_en && i_req[k] && (!w_found || (w_dist[k] < w_best))) begin
        w_found    = 1'b1;
        w_best     = w_dist[k];
        o_grant    = '0;
        o_grant[k] = 1'b1;
        o_idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/multiplier.sv
// ---------------------------------------------------------------------------
// multiplier
// Combinational radix-2 Booth multiplier for unsigned N-bit operands.
// Ports:
//   i_a, i_b : N-bit unsigned operands
//   o_p      : 2N+1-bit product
// Both operands are zero-extended so the Booth recoding sees a positive
// multiplier; all partial products are summed modulo 2^(2N+1), which is
// exact because the true product is below 2^(2N).
// ---------------------------------------------------------------------------
module multiplier #(
  parameter int N = 10
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [2*N:0] o_p
);

  localparam int PW = 2 * N + 1;

  logic [PW-1:0] w_a_ext;
  logic [N+1:0]  w_b_pad;
  logic [PW-1:0] w_pp [N+1];
  logic [PW-1:0] w_acc;

  assign w_a_ext = {{(N + 1){1'b0}}, i_a};
  // Implicit zero below bit 0 and zero sign bit above the MSB.
  assign w_b_pad = {1'b0, i_b, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi <= N; gi++) begin : g_pp
      logic [1:0] w_sel;
      assign w_sel = w_b_pad[gi+1:gi];
      // Booth digit = b[i-1] - b[i]: 01 -> +A, 10 -> -A, else 0.
      assign w_pp[gi] = (w_sel == 2'b01) ? (w_a_ext << gi) :
                        (w_sel == 2'b10) ? (-(w_a_ext << gi)) :
                        '0;
    end
  endgenerate

  always_comb begin
    w_acc = '0;
    for (int k = 0; k <= N; k++) begin
      w_acc = w_acc + w_pp[k];
    end
  end

  assign o_p = w_acc;

endmodule

// File: rtl/mul_sched.sv
// ---------------------------------------------------------------------------
// mul_sched
// Shares one combinational multiplier between NREQ requesters. A request is
// accepted in IDLE (round-robin), operands are registered, the multiplier is
// given LAT cycles to settle, and the registered product is held on the
// tagged response channel until the consumer takes it.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid / req_ready : per-requester handshake (req_ready one-hot or 0)
//   req_a, req_b          : per-requester N-bit operands
//   rsp_valid / rsp_ready : shared response handshake
//   rsp_id                : requester that owns rsp_result
//   rsp_result            : 2N+1-bit product
// ---------------------------------------------------------------------------
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter  int N    = N_DEF,
  parameter  int NREQ = 2,
  parameter  int LAT  = 2,
  localparam int IW   = ID_W(NREQ),
  localparam int RW   = RES_W(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0][N-1:0]   req_a,
  input  logic [NREQ-1:0][N-1:0]   req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IW-1:0]            rsp_id,
  output logic [RW-1:0]            rsp_result
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_t          r_state;
  state_t          w_state_next;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_id;
  logic [IW-1:0]   r_rsp_id;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic            r_valid;
  logic [RW-1:0]   r_result;

  logic            w_arb_en;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_accept;
  logic            w_cnt_done;
  logic [IW-1:0]   w_ptr_next;
  logic [RW-1:0]   w_prod;

  // Grants are only offered in IDLE, and never while reset is asserted.
  assign w_arb_en = (r_state == IDLE) && !rst;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  // The multiplier sees only registered operands, so its output is stable
  // for the whole WAIT window and can be treated as a multicycle path.
  multiplier #(
    .N (N)
  ) u_mul (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  assign req_ready  = w_grant;
  assign w_accept   = |(req_valid & w_grant);
  assign w_cnt_done = (r_cnt == '0);
  assign w_ptr_next = (w_idx == IW'(NREQ - 1)) ? '0 : (w_idx + IW'(1));

  assign rsp_valid  = r_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_next = WAIT;
      WAIT:    if (w_cnt_done) w_state_next = RESP;
      RESP:    if (rsp_ready)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_valid  <= 1'b0;
      r_rsp_id <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a   <= req_a[w_idx];
            r_b   <= req_b[w_idx];
            r_id  <= w_idx;
            r_ptr <= w_ptr_next;
            r_cnt <= CW'(LAT - 1);
          end
        end
        WAIT: begin
          if (w_cnt_done) begin
            r_result <= w_prod;
            r_rsp_id <= r_id;
            r_valid  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// ---------------------------------------------------------------------------
// tb_mul_sched
// Self-checking bench for mul_sched. Inputs are driven on the falling edge;
// every cycle the outputs are compared against a transaction-level model
// (round-robin pick, product = A*B captured at accept, response visible LAT
// edges after accept and held until taken).
// ---------------------------------------------------------------------------
module tb_mul_sched;

  localparam int N    = 10;
  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam int IW   = 1;
  localparam int RW   = 2 * N + 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][N-1:0] req_a = '0;
  logic [NREQ-1:0][N-1:0] req_b = '0;
  logic                   rsp_valid;
  logic                   rsp_ready = 1'b1;
  logic [IW-1:0]          rsp_id;
  logic [RW-1:0]          rsp_result;

  mul_sched #(
    .N    (N),
    .NREQ (NREQ),
    .LAT  (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_ptr       = 0;  // requester with top priority
  bit m_busy      = 0;  // an operation has been accepted and not yet returned
  bit m_rsp       = 0;  // response currently presented
  int m_wait      = 0;  // edges elapsed since accept
  int m_prod      = 0;
  int m_id        = 0;
  int m_last_prod = 0;  // value rsp_result should show
  int m_last_id   = 0;  // value rsp_id should show

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // Called just after a falling edge with inputs already driven: compare,
  // advance the model across the next rising edge, wait for the next fall.
  task automatic step();
    int g;
    logic [NREQ-1:0] exp_ready;
    #1;
    g = (rst || m_busy) ? -1 : rr_pick(req_valid, m_ptr);
    exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    check("req_ready",  32'(req_ready),  32'(exp_ready));
    check("rsp_valid",  32'(rsp_valid),  32'(m_rsp));
    check("rsp_id",     32'(rsp_id),     m_last_id);
    check("rsp_result", 32'(rsp_result), m_last_prod);

    if (rst) begin
      m_busy = 0; m_rsp = 0; m_ptr = 0; m_wait = 0;
      m_last_prod = 0; m_last_id = 0;
    end else if (!m_busy) begin
      if (g >= 0) begin
        m_busy = 1;
        m_wait = 0;
        m_id   = g;
        m_prod = int'(req_a[g]) * int'(req_b[g]);
        m_ptr  = (g + 1) % NREQ;
      end
    end else if (!m_rsp) begin
      m_wait++;
      if (m_wait == LAT) begin
        m_rsp       = 1;
        m_last_prod = m_prod;
        m_last_id   = m_id;
      end
    end else if (rsp_ready) begin
      $display("txn: id=%0d product=%0d", m_id, m_prod);
      m_rsp  = 0;
      m_busy = 0;
    end
    @(negedge clk);
  endtask

  // One request from requester 'id'; after the accept the operands change to
  // (a2,b2) and the response is back-pressured for 'bp' cycles.
  task automatic op(input int id, input int a, input int b, input int bp,
                    input int a2, input int b2);
    req_valid = NREQ'(1) << id;
    req_a[id] = N'(a);
    req_b[id] = N'(b);
    rsp_ready = 1'b1;
    step();
    req_valid = '0;
    req_a[id] = N'(a2);
    req_b[id] = N'(b2);
    repeat (LAT) step();
    rsp_ready = 1'b0;
    repeat (bp) step();
    rsp_ready = 1'b1;
    step();
    step();
  endtask

  task automatic rand_operands();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = N'($urandom);
      req_b[i] = N'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state, including no grant while requests are present in reset
    step();
    req_valid = '1;
    step();
    req_valid = '0;
    rst = 1'b0;

    // Single op and edge values
    op(0, 1, 1, 0, 5, 5);
    op(0, 0, 0, 0, 3, 3);
    op(1, 'h3F, 'h3F, 0, 1, 1);
    op(0, 1023, 1023, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      op(i % 2, $urandom_range(0, 1023), $urandom_range(0, 1023), 0,
         $urandom_range(0, 1023), $urandom_range(0, 1023));
    end

    // Contention from reset release: both requesters held valid
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (4 * (LAT + 2) + 2) begin
      rand_operands();
      step();
    end
    req_valid = '0;
    repeat (LAT + 3) step();

    // Backpressure for 5 cycles in RESP
    op(0, $urandom_range(1, 1023), $urandom_range(1, 1023), 5, 0, 0);

    // Operand change after accept
    op(1, 7, 9, 0, 2, 2);

    // Reset while in WAIT: operation dropped, no response
    req_valid = 2'b10;
    req_a[1]  = 10'd5;
    req_b[1]  = 10'd6;
    step();
    req_valid = '0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (LAT + 3) step();
    op(1, 11, 13, 0, 0, 0);

    // Random traffic: requests may drop before grant, random backpressure
    repeat (80) begin
      req_valid = NREQ'($urandom);
      rand_operands();
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
